dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): XLEN, 32, data/address width; ADDR_W, 12, SRAM word-address width; WAIT_CYCLES, 1, extra SRAM wait states (0..15).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with ports (name, direction, width, meaning) as in REQ-003..REQ-019.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  core load/store request.
REQ-006 req_ready  out  1  request accepted when high with req_valid.
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  in  1  zero-extend loads when 1.
REQ-010 req_addr  in  XLEN  byte address.
REQ-011 req_wdata  in  XLEN  store data, right-aligned.
REQ-012 rsp_valid  out  1  one-cycle response strobe.
REQ-013 rsp_rdata  out  XLEN  formatted load data; 0 for stores and faults.
REQ-014 rsp_fault  out  1  misaligned, illegal-size or out-of-range access.
REQ-015 mem_cs  out  1  SRAM chip select.
REQ-016 mem_we  out  1  SRAM write enable.
REQ-017 mem_be  out  4  SRAM byte enables.
REQ-018 mem_addr, mem_wdata  out  ADDR_W, XLEN  SRAM word address = req_addr[ADDR_W+1:2]; lane-replicated write data.
REQ-019 mem_rdata  in  XLEN  SRAM read data, valid from the cycle after mem_cs until the next mem_cs.

Function
REQ-020 The block SHALL implement the FSM IDLE, ACCESS, WAIT, RESP and SHALL assert req_ready only in IDLE.
REQ-021 In IDLE with req_valid=1, the block SHALL latch we, size, unsigned, addr and wdata at the accepting edge.
REQ-022 In IDLE with req_valid=1, the block SHALL go to RESP if faulting, otherwise to ACCESS.
REQ-023 A request SHALL fault when size=11, when size=01 and addr[0]=1, when size=10 and addr[1:0]!=0, or when addr[XLEN-1:ADDR_W+2]!=0.
REQ-024 A faulting request SHALL never assert mem_cs.
REQ-025 In ACCESS, mem_cs SHALL be 1 for exactly one cycle with mem_we, mem_be, mem_addr and mem_wdata driven from the latched request.
REQ-026 In ACCESS, the next state SHALL be WAIT.
REQ-027 A wait counter SHALL load WAIT_CYCLES in ACCESS and decrement in WAIT.
REQ-028 The block SHALL stay in WAIT for 1+WAIT_CYCLES cycles and SHALL go to RESP when the counter is 0.
REQ-029 On the WAIT-exit edge, the block SHALL register formatted mem_rdata into rsp_rdata for loads and 0 for stores.
REQ-030 In RESP, rsp_valid SHALL be 1 for exactly one cycle with rsp_fault valid, then the FSM SHALL return to IDLE.
REQ-031 rsp_rdata and rsp_fault SHALL hold until the next response.
REQ-032 Latency SHALL be: accept edge T, ACCESS cycle T+1, RESP cycle T+3+WAIT_CYCLES; fault RESP cycle T+1.
REQ-033 Throughput SHALL be one request per 4+WAIT_CYCLES cycles.
REQ-034 req_valid outside IDLE SHALL be ignored; the request is held by the core until req_ready.
REQ-035 Byte enables SHALL be: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111.
REQ-036 Store data SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
REQ-037 Loads SHALL select byte lane addr[1:0] or half lane addr[1] and sign-extend unless unsigned; word loads pass through.
REQ-038 The response channel SHALL have no backpressure; the core always consumes rsp_valid.

Reset
REQ-039 While rstn=0, the FSM SHALL be in IDLE, all outputs except req_ready SHALL be 0, and req_ready SHALL be 1 immediately (asynchronously).
REQ-040 A reset mid-transaction SHALL abort the transaction: no response, mem_cs drops asynchronously, and the counter clears.

Verification (WAIT_CYCLES=1, ADDR_W=12)
REQ-041 Store word 0xDEADBEEF to 0x10 -> ACCESS: cs=1, we=1, be=1111, addr=0x004, wdata=0xDEADBEEF; rsp_valid 4 cycles after accept, fault=0, rdata=0.
REQ-042 Load byte at 0x13 with mem_rdata=0x80FF7F01 -> rsp_rdata=0xFFFFFF80 signed, 0x00000080 unsigned; half at 0x12 signed -> 0xFFFF80FF.
REQ-043 Store half 0x1234ABCD to 0x22 -> be=1100, wdata=0xABCDABCD, addr=0x008.
REQ-044 Word load at 0x6, size=11 at 0x0, and word at 0x4000 -> each gives rsp_valid=1, fault=1 one cycle after accept; mem_cs never 1.
REQ-045 rstn low during WAIT -> all outputs 0 at once, no rsp_valid; after release, load word 0x0 completes normally.
REQ-046 req_valid held high for two requests -> second accepted only in the IDLE cycle after RESP; accepts 5 cycles apart.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Core load/store port and SRAM port of the data-memory controller.
// master: the core and SRAM side. slave: the controller.
interface dmem_ctrl_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 12
);
    // Core request / response channel
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_fault;

    // Single-port SRAM channel
    logic              mem_cs;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
               mem_cs, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
               mem_cs, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns byte/half/word core loads and stores into
// single SRAM word accesses with lane steering, alignment and range checks.
module dmem_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    dmem_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        addr_q;

    logic              fault_c;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   wdata_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [XLEN-1:0]   rdata_fmt_c;

    // Classify the incoming request: alignment, size and address range
    always_comb begin
        fault_c = 1'b0;
        case (bus.req_size)
            2'b00:   fault_c = 1'b0;
            2'b01:   fault_c = bus.req_addr[0];
            2'b10:   fault_c = |bus.req_addr[1:0];
            default: fault_c = 1'b1;
        endcase
        if ((bus.req_addr >> (ADDR_W + 2)) != '0) begin
            fault_c = 1'b1;
        end
    end

    // Byte enables and lane-replicated store data for the incoming request
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                be_c    = 4'b0001 << bus.req_addr[1:0];
                wdata_c = {(XLEN/8){bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {(XLEN/16){bus.req_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = bus.req_wdata;
            end
        endcase
    end

    // Select and extend the addressed lane of the SRAM read word
    always_comb begin
        byte_c      = 8'(bus.mem_rdata >> {addr_q, 3'b000});
        half_c      = 16'(bus.mem_rdata >> {addr_q[1], 4'b0000});
        rdata_fmt_c = '0;
        if (!we_q) begin
            case (size_q)
                2'b00:   rdata_fmt_c = {{(XLEN-8){byte_c[7] & ~uns_q}}, byte_c};
                2'b01:   rdata_fmt_c = {{(XLEN-16){half_c[15] & ~uns_q}}, half_c};
                default: rdata_fmt_c = bus.mem_rdata;
            endcase
        end
    end

    // Transaction FSM with registered SRAM and response outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            addr_q        <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_fault <= 1'b0;
            bus.mem_cs    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we_q          <= bus.req_we;
                        size_q        <= bus.req_size;
                        uns_q         <= bus.req_unsigned;
                        addr_q        <= bus.req_addr[1:0];
                        bus.req_ready <= 1'b0;
                        if (fault_c) begin
                            // Faults skip the SRAM entirely and answer next cycle
                            state         <= S_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_fault <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end else begin
                            state         <= S_ACCESS;
                            bus.mem_cs    <= 1'b1;
                            bus.mem_we    <= bus.req_we;
                            bus.mem_be    <= be_c;
                            bus.mem_addr  <= ADDR_W'(bus.req_addr >> 2);
                            bus.mem_wdata <= wdata_c;
                        end
                    end
                end
                S_ACCESS: begin
                    state         <= S_WAIT;
                    cnt_q         <= CNT_W'(WAIT_CYCLES);
                    bus.mem_cs    <= 1'b0;
                    bus.mem_we    <= 1'b0;
                    bus.mem_be    <= '0;
                    bus.mem_addr  <= '0;
                    bus.mem_wdata <= '0;
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state         <= S_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_fault <= 1'b0;
                        bus.rsp_rdata <= rdata_fmt_c;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state         <= S_IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
